// File: rtl/sha256_digest_streamer.sv
// rtl/sha256_digest_streamer.sv - streams a captured SHA-256 digest as raw bytes or ASCII hex over a valid/ready byte port
module sha256_digest_streamer #(
  parameter bit HEX_UPPER      = 1'b0,
  parameter bit APPEND_NEWLINE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] digest_in,
  input  logic         digest_valid,
  input  logic         hex_mode,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         tx_last,
  output logic         busy,
  output logic         overrun,
  input  logic         overrun_clr
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t       state, state_d;
  logic [255:0] digest_q;
  logic         hex_q;
  logic [6:0]   index, index_d;
  logic [6:0]   last_idx;
  logic         dv_prev;
  logic         dv_edge;
  logic         final_hs;
  logic         capture;
  logic         overrun_set;
  logic [7:0]   raw_bytes [32];
  logic [3:0]   nibbles   [64];
  logic [3:0]   nib;
  logic [7:0]   hex_char;

  assign dv_edge  = digest_valid && !dv_prev;
  assign last_idx = hex_q ? (APPEND_NEWLINE ? 7'd64 : 7'd63) : 7'd31;
  assign final_hs = (state == SEND) && tx_ready && (index == last_idx);

  always_comb begin
    state_d     = state;
    index_d     = index;
    capture     = 1'b0;
    overrun_set = 1'b0;
    case (state)
      IDLE: begin
        if (dv_edge) begin
          capture = 1'b1;
          state_d = SEND;
          index_d = 7'd0;
        end
      end
      SEND: begin
        if (final_hs) begin
          // A fresh digest landing on the last handshake chains straight into a new stream.
          index_d = 7'd0;
          if (dv_edge) capture = 1'b1;
          else         state_d = IDLE;
        end else begin
          if (tx_ready) index_d = index + 7'd1;
          if (dv_edge)  overrun_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      index    <= 7'd0;
      digest_q <= '0;
      hex_q    <= 1'b0;
      dv_prev  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state   <= state_d;
      index   <= index_d;
      dv_prev <= digest_valid;
      if (capture) begin
        digest_q <= digest_in;
        hex_q    <= hex_mode;
      end
      if (overrun_set)      overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

  for (genvar g = 0; g < 32; g++) begin : g_bytes
    assign raw_bytes[g] = digest_q[255-8*g -: 8];
  end
  for (genvar g = 0; g < 64; g++) begin : g_nibbles
    assign nibbles[g] = digest_q[255-4*g -: 4];
  end

  assign nib = nibbles[index[5:0]];

  always_comb begin
    hex_char = 8'h0A;
    if (!index[6]) begin
      if (nib < 4'd10) hex_char = 8'h30 + {4'h0, nib};
      else             hex_char = (HEX_UPPER ? 8'h41 : 8'h61) + {4'h0, nib} - 8'd10;
    end
  end

  assign tx_valid = (state == SEND);
  assign busy     = (state == SEND);
  assign tx_last  = tx_valid && (index == last_idx);
  assign tx_data  = !tx_valid ? 8'h00 : (hex_q ? hex_char : raw_bytes[index[4:0]]);

endmodule
